timer_irq_source: RTL and testbench

- Memory-mapped countdown timer. It is the interrupt source that drives one bit of the CPU's 6-bit hardware interrupt vector (HWInt[2]).
- It receives the processor's interrupt-response strobe back as int_ack.
- Software programs it through word-addressed bridge writes: CTRL, PRESET, and read-only COUNT.
- It sits on the system bridge beside other peripherals, and its irq output feeds the coprocessor's interrupt inputs.

---
 rtl/timer_irq_source.sv | 73 +++++++
 tb/tb_timer_irq_source.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped countdown timer driving HWInt[2]; define TIMER_PRESCALE_EN to add the count prescaler
module timer_irq_source #(
  parameter int PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        int_ack,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t state, state_next;
  logic [3:0] ctrl;
  logic [31:0] preset, count;
  logic irq_flag, tick, en, auto_reload, ctrl_we, preset_we;
  assign en = ctrl[0];
  assign auto_reload = ctrl[2:1] == 2'd1;
  assign ctrl_we = we && addr == 2'd0;
  assign preset_we = we && addr == 2'd1;
`ifdef TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE_DIV) + 1;
  logic [PW-1:0] pre;
  assign tick = pre == PW'(PRESCALE_DIV - 1);
  // prescale counter: zeroed on load, free-runs while counting and wraps on each tick
  always_ff @(posedge clk or posedge reset)
    if (reset) pre <= '0;
    else if (state == LOAD) pre <= '0;
    else if (state == CNT) pre <= tick ? '0 : pre + 1'b1;
`else
  assign tick = PRESCALE_DIV > 0;
`endif
  // next-state: EN is sampled every cycle, the zero test only on ticks
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = en ? LOAD : IDLE;
      LOAD: state_next = CNT;
      CNT: state_next = !en ? IDLE : (tick && count == '0) ? INT : CNT;
      INT: state_next = auto_reload ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // bus writes win over the one-shot EN clear at interrupt
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctrl <= '0;
      preset <= '0;
    end else begin
      if (ctrl_we) ctrl <= wdata[3:0];
      else if (state == INT && !auto_reload) ctrl[0] <= 1'b0;
      if (preset_we) preset <= wdata;
    end
  // COUNT loads from PRESET and steps down on live ticks, never below zero
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (state == LOAD) count <= preset;
    else if (state == CNT && en && tick && count != '0) count <= count - 1'b1;
  // irq_flag: CTRL write clears, INT sets, then ack or pulse expiry clears
  always_ff @(posedge clk or posedge reset)
    if (reset) irq_flag <= 1'b0;
    else if (ctrl_we) irq_flag <= 1'b0;
    else if (state == INT) irq_flag <= 1'b1;
    else if (int_ack || auto_reload) irq_flag <= 1'b0;
  assign rdata = addr == 2'd0 ? {28'b0, ctrl} : addr == 2'd1 ? preset : addr == 2'd2 ? count : '0;
  assign irq = irq_flag & ctrl[3];
endmodule

// File: tb/tb_timer_irq_source.sv
// tb_timer_irq_source: vector table, corner sequences and random traffic against a reference model
module tb_timer_irq_source;
`ifdef TIMER_PRESCALE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif
  logic clk = 0, reset = 1, we = 0, int_ack = 0, irq;
  logic [1:0] addr = 0;
  logic [31:0] wdata = 0, rdata;
  int checks = 0, errors = 0;
  logic [3:0] m_ctrl;
  logic [31:0] m_preset, m_count;
  logic m_flag;
  int m_phase, m_pre;
  typedef struct packed {
    logic [1:0] a;
    logic w;
    logic [31:0] d;
    logic k;
    logic [31:0] er;
    logic ei;
  } vec_t;
  vec_t tv[$];

  timer_irq_source #(.PRESCALE_DIV(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .int_ack(int_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task m_reset();
    m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = 0; m_pre = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    return a == 0 ? {28'b0, m_ctrl} : a == 1 ? m_preset : a == 2 ? m_count : 32'd0;
  endfunction

  // phases: 0 idle, 1 load, 2 counting, 3 interrupt; all next values come from pre-edge values
  task model_edge(input logic [1:0] a, input logic w, input logic [31:0] d, input logic k);
    logic [3:0] c;
    logic [31:0] p, n;
    logic f;
    int ph, pr;
    bit tick, en, auto;
    c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_phase; pr = m_pre;
    en = m_ctrl[0];
    auto = m_ctrl[2:1] == 2'd1;
    tick = m_pre == D - 1;
    if (m_flag && auto) f = 0;
    if (k) f = 0;
    if (m_phase == 3) f = 1;
    if (w && a == 0) f = 0;
    if (m_phase == 0) begin
      if (en) ph = 1;
    end else if (m_phase == 1) begin
      n = m_preset; ph = 2; pr = 0;
    end else if (m_phase == 2) begin
      pr = tick ? 0 : m_pre + 1;
      if (!en) ph = 0;
      else if (tick && m_count == 0) ph = 3;
      else if (tick) n = m_count - 1;
    end else begin
      ph = auto ? 1 : 0;
      if (!auto) c[0] = 0;
    end
    if (w && a == 0) c = d[3:0];
    if (w && a == 1) p = d;
    m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_phase = ph; m_pre = pr;
  endtask

  task automatic step(input logic [1:0] a, input logic w, input logic [31:0] d, input logic k);
    addr = a; we = w; wdata = d; int_ack = k;
    @(posedge clk);
    model_edge(a, w, d, k);
    #1;
    we = 0; int_ack = 0;
    check("model_irq", {31'b0, irq}, {31'b0, m_flag & m_ctrl[3]});
    check("model_rdata", rdata, m_read(addr));
  endtask

  task automatic wait_irq(input string name, input int exp);
    int e;
    e = 0;
    while (!irq && e < 40 * D + 40) begin
      step(2, 0, 0, 0);
      e++;
    end
    check(name, e, exp);
  endtask

  initial begin
    int e, last, pulses;
    logic [31:0] hold;
    logic [1:0] ra;
    m_reset();
    repeat (2) @(posedge clk);
    #2 reset = 0;
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1 check("reset_rdata", rdata, 0);
    end
    check("reset_irq", {31'b0, irq}, 0);
`ifndef TIMER_PRESCALE_EN
    tv.push_back({2'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd3, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd1, 1'b1, 32'd3, 1'b0, 32'd3, 1'b0});
    tv.push_back({2'd0, 1'b1, 32'h9, 1'b0, 32'h9, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd3, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd2, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd1, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1});
    tv.push_back({2'd0, 1'b0, 32'd0, 1'b0, 32'h8, 1'b1});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0});
    tv.push_back({2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd0, 1'b0, 32'd0, 1'b0, 32'h8, 1'b0});
    tv.push_back({2'd2, 1'b1, 32'hFFFF, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd3, 1'b1, 32'h55, 1'b0, 32'd0, 1'b0});
    tv.push_back({2'd1, 1'b0, 32'd0, 1'b0, 32'd3, 1'b0});
    tv.push_back({2'd0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'd0, 1'b0});
    foreach (tv[i]) begin
      step(tv[i].a, tv[i].w, tv[i].d, tv[i].k);
      check($sformatf("vec%0d_rdata", i), rdata, tv[i].er);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tv[i].ei});
    end
`endif
    step(1, 1, 3, 0);
    step(0, 1, 32'h9, 0);
    wait_irq("oneshot_latency", 4 * D + 3);
    step(2, 0, 0, 1);
    check("ack_clears_irq", {31'b0, irq}, 0);
    check("ack_count_zero", rdata, 0);
    step(1, 1, 2, 0);
    step(0, 1, 32'hB, 0);
    last = -1; pulses = 0; e = 0;
    while (pulses < 5 && e < 100 * D) begin
      step(2, 0, 0, 0);
      e++;
      if (irq) begin
        if (last < 0) check("m1_first", e, 3 * D + 3);
        else check("m1_period", e - last, 3 * D + 2);
        last = e;
        pulses++;
      end
    end
    check("m1_pulses", pulses, 5);
    step(0, 1, 0, 0);
    repeat (3) step(2, 0, 0, 0);
    step(1, 1, 10, 0);
    step(0, 1, 32'h9, 0);
    e = 0;
    while (rdata != 7 && e < 40 * D) begin
      step(2, 0, 0, 0);
      e++;
    end
    check("freeze_reach7", rdata, 7);
    step(1, 1, 1, 0);
    step(0, 1, 32'h8, 0);
    step(2, 0, 0, 0);
    hold = m_count;
    repeat (5) step(2, 0, 0, 0);
    check("freeze_hold", rdata, hold);
    check("freeze_noirq", {31'b0, irq}, 0);
    step(0, 1, 32'h9, 0);
    wait_irq("reload_latency", 2 * D + 3);
    step(0, 1, 0, 0);
    step(1, 1, 8, 0);
    step(0, 1, 32'hB, 0);
    e = 0;
    while (rdata != 5 && e < 40 * D) begin
      step(2, 0, 0, 0);
      e++;
    end
    check("pre_reset_count", rdata, 5);
    #2 reset = 1;
    m_reset();
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1 check("async_reset_rdata", rdata, 0);
      check("async_reset_irq", {31'b0, irq}, 0);
    end
    @(posedge clk);
    #1 check("held_reset_irq", {31'b0, irq}, 0);
    #2 reset = 0;
    step(1, 1, 0, 0);
    step(0, 1, 32'h9, 0);
    repeat (D + 2) step(2, 0, 0, 0);
    addr = 0;
    step(0, 1, 32'h9, 0);
    check("wr_vs_int_irq", {31'b0, irq}, 0);
    check("wr_vs_int_ctrl", rdata, 32'h9);
    repeat (D + 2) step(2, 0, 0, 0);
    step(2, 0, 0, 1);
    check("ack_vs_set_irq", {31'b0, irq}, 1);
    step(2, 0, 0, 1);
    check("ack_after_set_irq", {31'b0, irq}, 0);
    step(0, 1, 0, 0);
    repeat (3) step(2, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      ra = 2'($urandom_range(0, 3));
      step(ra, $urandom_range(0, 3) == 0, ra == 1 ? $urandom_range(0, 5) : $urandom, $urandom_range(0, 7) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
